// File: rtl/serializer_param.sv
// Parallel-to-serial burst shifter with variable burst length
// and a one-word holding buffer for gapless back-to-back bursts.
module serializer_param #(
    parameter int DATA_W    = 16,
    parameter int MOD_W     = $clog2(DATA_W),
    parameter int MIN_LEN   = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    output logic              busy_o
);

    localparam int CW = ($clog2(DATA_W + 1) > MOD_W + 1) ?
                        $clog2(DATA_W + 1) : MOD_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] buf_data;
    logic [CW-1:0]     buf_len;
    logic              buf_full;

    logic [CW-1:0]     in_len;
    logic              take;
    logic              load_in;
    logic              last;
    logic [DATA_W-1:0] shreg_nxt;
    logic              cur_bit;

    // Lengths above DATA_W (non power-of-two widths) clamp to a full word
    always_comb begin
        in_len = (data_mod_i == '0) ? CW'(DATA_W) : CW'(data_mod_i);
        if (in_len > CW'(DATA_W))
            in_len = CW'(DATA_W);
    end

    assign take    = data_val_i & ready_o;
    assign load_in = take & (in_len >= CW'(MIN_LEN));
    assign last    = (state == SHIFT) && (cnt == CW'(1));

    assign shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    assign cur_bit   = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            buf_data <= '0;
            buf_len  <= '0;
            buf_full <= 1'b0;
            ready_o  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_in) begin
                        shreg <= data_i;
                        cnt   <= in_len;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        if (buf_full) begin
                            shreg    <= buf_data;
                            cnt      <= buf_len;
                            buf_full <= 1'b0;
                            ready_o  <= 1'b1;
                        end else if (load_in) begin
                            shreg <= data_i;
                            cnt   <= in_len;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        shreg <= shreg_nxt;
                        cnt   <= cnt - CW'(1);
                        if (load_in) begin
                            buf_data <= data_i;
                            buf_len  <= in_len;
                            buf_full <= 1'b1;
                            ready_o  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ser_data_val_o = (state == SHIFT);
    assign ser_data_o     = ser_data_val_o & cur_bit;
    assign ser_last_o     = last;
    assign busy_o         = (state == SHIFT) | buf_full;

endmodule

// File: tb/tb_serializer_param.sv
// Scoreboard bench for serializer_param: MSB-first and LSB-first
// instances share one stimulus stream, each with its own queue.
module tb_serializer_param;

    typedef struct packed {
        logic b;
        logic l;
    } sbit_t;

    logic        clk = 1'b0;
    logic        arst;
    logic [15:0] data;
    logic [3:0]  mod;
    logic        val;

    logic rdy, sd, sv, sl, bsy;
    logic rdy_l, sd_l, sv_l, sl_l, bsy_l;

    sbit_t q[$];
    sbit_t ql[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serializer_param #(
        .DATA_W(16), .MOD_W(4), .MIN_LEN(3), .MSB_FIRST(1'b1)
    ) dut (
        .clk_i(clk), .arst_i(arst), .data_i(data),
        .data_mod_i(mod), .data_val_i(val), .ready_o(rdy),
        .ser_data_o(sd), .ser_data_val_o(sv),
        .ser_last_o(sl), .busy_o(bsy)
    );

    serializer_param #(
        .DATA_W(16), .MOD_W(4), .MIN_LEN(3), .MSB_FIRST(1'b0)
    ) dut_l (
        .clk_i(clk), .arst_i(arst), .data_i(data),
        .data_mod_i(mod), .data_val_i(val), .ready_o(rdy_l),
        .ser_data_o(sd_l), .ser_data_val_o(sv_l),
        .ser_last_o(sl_l), .busy_o(bsy_l)
    );

    task automatic monitor();
        sbit_t e;
        forever begin
            @(negedge clk);
            if (!arst) begin
                checks++;
                if (sv) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL msb_extra_bit got d=%0b l=%0b required none", sd, sl);
                    end else begin
                        e = q.pop_front();
                        if ({sd, sl} !== {e.b, e.l}) begin
                            errors++;
                            $display("FAIL msb_bit got d=%0b l=%0b required d=%0b l=%0b",
                                     sd, sl, e.b, e.l);
                        end
                    end
                end else if ({sd, sl} !== 2'b00) begin
                    errors++;
                    $display("FAIL msb_idle_out got d=%0b l=%0b required 0 0", sd, sl);
                end
                checks++;
                if (sv_l) begin
                    if (ql.size() == 0) begin
                        errors++;
                        $display("FAIL lsb_extra_bit got d=%0b l=%0b required none", sd_l, sl_l);
                    end else begin
                        e = ql.pop_front();
                        if ({sd_l, sl_l} !== {e.b, e.l}) begin
                            errors++;
                            $display("FAIL lsb_bit got d=%0b l=%0b required d=%0b l=%0b",
                                     sd_l, sl_l, e.b, e.l);
                        end
                    end
                end else if ({sd_l, sl_l} !== 2'b00) begin
                    errors++;
                    $display("FAIL lsb_idle_out got d=%0b l=%0b required 0 0", sd_l, sl_l);
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic put(input logic [15:0] d, input logic [3:0] m);
        int n = 0;
        int len;
        data = d;
        mod  = m;
        val  = 1'b1;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL put_timeout ready got %0b required 1", rdy);
        end
        len = (m == 4'd0) ? 16 : int'(m);
        if (rdy && len >= 3) begin
            for (int i = 0; i < len; i++) begin
                q.push_back(sbit_t'{d[15-i], (i == len - 1)});
                ql.push_back(sbit_t'{d[i], (i == len - 1)});
            end
        end
        @(negedge clk);
        val = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((bsy || q.size() != 0 || ql.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || ql.size() != 0 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL drain left q=%0d ql=%0d busy=%0b required 0 0 0",
                     q.size(), ql.size(), bsy);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        val  = 1'b0;
        data = '0;
        mod  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sv, sd, sl, bsy, rdy} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_msb got %b required 00001", {sv, sd, sl, bsy, rdy});
        end
        checks++;
        if ({sv_l, sd_l, sl_l, bsy_l, rdy_l} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_lsb got %b required 00001",
                     {sv_l, sd_l, sl_l, bsy_l, rdy_l});
        end
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb();
        int n;
        put(16'hA5F0, 4'd0);
        checks++;
        if (sv !== 1'b1) begin
            errors++;
            $display("FAIL msb_latency val got %0b required 1", sv);
        end
        n = sv ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sv) n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL msb_val_cycles got %0d required 16", n);
        end
        drain();
    endtask

    task automatic test_short();
        int n;
        put(16'hF800, 4'd5);
        n = sv ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sv) n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL short5_val_cycles got %0d required 5", n);
        end
        put(16'h1234, 4'd2);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rdy !== 1'b1 || bsy !== 1'b0) begin
                errors++;
                $display("FAIL short2_ready_busy got %0b%0b required 10", rdy, bsy);
            end
            if (sv) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL short2_val_cycles got %0d required 0", n);
        end
        drain();
    endtask

    task automatic test_lsb();
        logic [3:0] got = '0;
        int n = 0;
        put(16'h000B, 4'd4);
        for (int k = 0; k < 8; k++) begin
            if (sv_l && n < 4) begin
                got[n] = sd_l;
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 4 || got !== 4'b1011) begin
            errors++;
            $display("FAIL lsb_bits got n=%0d bits=%b required n=4 bits=1011", n, got);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        put(16'hC3A5, 4'd0);
        put(16'h6000, 4'd3);
        while (!sl && k < 40) begin
            checks++;
            if (rdy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_while_full got %0b required 0", rdy);
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (!sl) begin
            errors++;
            $display("FAIL b2b_last_timeout last got %0b required 1", sl);
        end
        @(negedge clk);
        checks++;
        if ({sv, rdy} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_no_gap val,ready got %b required 11", {sv, rdy});
        end
        drain();
    endtask

    task automatic test_reset_mid();
        put(16'hA5F0, 4'd0);
        put(16'hE000, 4'd3);
        repeat (5) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        checks++;
        if ({sv, sd, sl, bsy, rdy} !== 5'b00001) begin
            errors++;
            $display("FAIL midrst_msb got %b required 00001", {sv, sd, sl, bsy, rdy});
        end
        checks++;
        if ({sv_l, bsy_l, rdy_l} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_lsb got %b required 001", {sv_l, bsy_l, rdy_l});
        end
        q.delete();
        ql.delete();
        data = 16'hFFFF;
        mod  = 4'd0;
        val  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        val  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sv, bsy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_edge_accept val,busy got %b required 00", {sv, bsy});
        end
        put(16'h8001, 4'd0);
        drain();
    endtask

    task automatic test_random();
        for (int w = 0; w < 1000; w++) begin
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            put(16'($urandom), 4'($urandom_range(0, 15)));
        end
        drain();
    endtask

    initial begin
        arst = 1'b1;
        val  = 1'b0;
        data = '0;
        mod  = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_msb();
        test_short();
        test_lsb();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
